// File: rtl/onehot_regbank_if.sv
// Bus bundle for onehot_regbank: decoder-driven write side, two read ports and error status.
interface onehot_regbank_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = 4
);
    logic [7:0]       we_onehot;
    logic [WIDTH-1:0] wdata;
    logic [2:0]       raddr1;
    logic [2:0]       raddr2;
    logic             clr_err;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    logic             err;
    logic [CNTW-1:0]  err_cnt;

    modport master (
        output we_onehot, wdata, raddr1, raddr2, clr_err,
        input  rdata1, rdata2, err, err_cnt
    );

    modport slave (
        input  we_onehot, wdata, raddr1, raddr2, clr_err,
        output rdata1, rdata2, err, err_cnt
    );
endinterface

// File: rtl/onehot_regbank.sv
// Eight-entry register bank written by a one-hot enable, entry 0 hardwired to zero.
// Optional macro REGBANK_BYPASS_EN forwards same-cycle write data to the read ports.
module onehot_regbank #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = 4
) (
    input logic              clk,
    input logic              rst_n,
    onehot_regbank_if.slave  bus
);

    logic [7:0]       we;
    logic             multi_hot;
    logic             legal;
    logic [WIDTH-1:0] mem_q [8];
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic [WIDTH-1:0] rdata2_q, rdata2_d;
    logic             err_q, err_d;
    logic [CNTW-1:0]  err_cnt_q, err_cnt_d;

    assign we = bus.we_onehot;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_hot = |(we & (we - 8'd1));
    assign legal     = (we != 8'd0) && !multi_hot;

    function automatic logic [WIDTH-1:0] read_port(input logic [2:0] addr);
        logic [WIDTH-1:0] val;
        val = (addr == 3'd0) ? '0 : mem_q[addr];
`ifdef REGBANK_BYPASS_EN
        if (legal && we[addr] && (addr != 3'd0)) begin
            val = bus.wdata;
        end
`endif
        return val;
    endfunction

    always_comb begin
        rdata1_d  = read_port(bus.raddr1);
        rdata2_d  = read_port(bus.raddr2);
        // Clear takes effect before a same-cycle illegal vector is counted.
        err_d     = bus.clr_err ? 1'b0 : err_q;
        err_cnt_d = bus.clr_err ? '0 : err_cnt_q;
        if (multi_hot) begin
            err_d = 1'b1;
            if (err_cnt_d != {CNTW{1'b1}}) begin
                err_cnt_d = err_cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[k] <= '0;
            end
            rdata1_q  <= '0;
            rdata2_q  <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            for (int k = 1; k < 8; k++) begin
                if (legal && we[k]) begin
                    mem_q[k] <= bus.wdata;
                end
            end
            rdata1_q  <= rdata1_d;
            rdata2_q  <= rdata2_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.rdata1  = rdata1_q;
    assign bus.rdata2  = rdata2_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_onehot_regbank.sv
// Self-checking bench for onehot_regbank: directed plan steps plus randomized traffic vs. a model.
module tb_onehot_regbank;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNTW  = 4;
    localparam int unsigned CMAX  = (1 << CNTW) - 1;

    logic clk;
    logic rst_n;

    onehot_regbank_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    onehot_regbank #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;

    // Reference model: plain array of entry values plus error flag and count.
    logic [WIDTH-1:0] m_mem [8];
    logic             m_err;
    int unsigned      m_cnt;
    logic [WIDTH-1:0] m_rd1;
    logic [WIDTH-1:0] m_rd2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_err = 1'b0;
        m_cnt = 0;
        m_rd1 = '0;
        m_rd2 = '0;
    endtask

    function automatic logic [WIDTH-1:0] model_read(input logic [2:0] a, input logic [7:0] we,
                                                     input logic [WIDTH-1:0] wd);
        if (a == 3'd0) return '0;
`ifdef REGBANK_BYPASS_EN
        if ($countones(we) == 1 && we[a]) return wd;
`endif
        return m_mem[a];
    endfunction

    // Drive one cycle from a negedge, advance the model, check all outputs after the posedge.
    task automatic step(input string tag, input logic [7:0] we, input logic [WIDTH-1:0] wd,
                        input logic [2:0] a1, input logic [2:0] a2, input logic clr);
        int ones;
        bus.we_onehot = we;
        bus.wdata     = wd;
        bus.raddr1    = a1;
        bus.raddr2    = a2;
        bus.clr_err   = clr;
        ones  = $countones(we);
        m_rd1 = model_read(a1, we, wd);
        m_rd2 = model_read(a2, we, wd);
        if (ones == 1) begin
            for (int i = 1; i < 8; i++) if (we[i]) m_mem[i] = wd;
        end
        if (clr) begin
            m_err = 1'b0;
            m_cnt = 0;
        end
        if (ones >= 2) begin
            m_err = 1'b1;
            if (m_cnt < CMAX) m_cnt++;
        end
        @(posedge clk);
        #1;
        check({tag, "_rdata1"}, 64'(bus.rdata1), 64'(m_rd1));
        check({tag, "_rdata2"}, 64'(bus.rdata2), 64'(m_rd2));
        check({tag, "_err"}, 64'(bus.err), 64'(m_err));
        check({tag, "_err_cnt"}, 64'(bus.err_cnt), 64'(m_cnt));
        @(negedge clk);
    endtask

    task automatic idle();
        bus.we_onehot = '0;
        bus.wdata     = '0;
        bus.raddr1    = '0;
        bus.raddr2    = '0;
        bus.clr_err   = 1'b0;
    endtask

    initial begin
        logic [7:0]       we;
        logic [WIDTH-1:0] wd;
        logic [7:0]       dec;
        int               r;
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rdata1", 64'(bus.rdata1), 64'h0);
        check("reset_rdata2", 64'(bus.rdata2), 64'h0);
        check("reset_err", 64'(bus.err), 64'h0);
        check("reset_err_cnt", 64'(bus.err_cnt), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Legal write then read back.
        step("wr2", 8'b0000_0100, 32'hA5A5_A5A5, 3'd2, 3'd0, 1'b0);
        step("rd2", 8'b0000_0000, 32'h0, 3'd2, 3'd2, 1'b0);
        check("rd2_const", 64'(bus.rdata1), 64'hA5A5_A5A5);

        // x0 rule.
        step("wr0", 8'b0000_0001, 32'hFFFF_FFFF, 3'd0, 3'd0, 1'b0);
        step("rd0", 8'b0000_0000, 32'h0, 3'd1, 3'd0, 1'b0);
        check("rd0_const", 64'(bus.rdata2), 64'h0);

        // Multi-hot: entries 1 and 3 must not change.
        step("wr3", 8'b0000_1000, 32'h11, 3'd0, 3'd0, 1'b0);
        step("mh", 8'b0000_1010, 32'h99, 3'd0, 3'd0, 1'b0);
        check("mh_cnt_const", 64'(bus.err_cnt), 64'h1);
        step("mh_rd", 8'b0000_0000, 32'h0, 3'd3, 3'd1, 1'b0);
        check("mh_e3_const", 64'(bus.rdata1), 64'h11);
        for (int i = 0; i < 16; i++) step("mh_sat", 8'b1100_0000, 32'h77, 3'd3, 3'd6, 1'b0);
        check("sat_const", 64'(bus.err_cnt), 64'(CMAX));
        step("clr", 8'b0000_0000, 32'h0, 3'd0, 3'd0, 1'b1);
        check("clr_const", 64'({bus.err, bus.err_cnt}), 64'h0);
        step("clr_mh", 8'b0011_0000, 32'h5, 3'd0, 3'd0, 1'b1);
        check("clr_mh_const", 64'({bus.err, bus.err_cnt}), 64'h11);

        // Same-cycle read/write on entry 5.
        step("wr5", 8'b0010_0000, 32'h22, 3'd0, 3'd0, 1'b0);
        step("rw5", 8'b0010_0000, 32'h33, 3'd5, 3'd0, 1'b0);
`ifdef REGBANK_BYPASS_EN
        check("rw5_const", 64'(bus.rdata1), 64'h33);
`else
        check("rw5_const", 64'(bus.rdata1), 64'h22);
`endif
        step("rw5_next", 8'b0000_0000, 32'h0, 3'd5, 3'd5, 1'b0);
        check("rw5_next_const", 64'(bus.rdata1), 64'h33);

        // Async reset between edges.
        for (int i = 1; i < 8; i++) step("load", 8'(1 << i), 32'(32'hC0 + i), 3'(i), 3'(i), 1'b0);
        step("load_err", 8'b1000_0001, 32'h0, 3'd4, 3'd7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rdata1", 64'(bus.rdata1), 64'h0);
        check("arst_rdata2", 64'(bus.rdata2), 64'h0);
        check("arst_err", 64'(bus.err), 64'h0);
        check("arst_err_cnt", 64'(bus.err_cnt), 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < 8; i++) step("arst_rd", 8'h00, 32'h0, 3'(i), 3'(8 - i), 1'b0);

        // Decoder chain: e=1 sweep, then e=0 writes nothing.
        for (int a = 0; a < 8; a++) begin
            dec = 8'(1 << a);
            step("dec_wr", dec, 32'(a + 32'h100), 3'd0, 3'd0, 1'b0);
        end
        step("dec_off", 8'h00, 32'hDEAD_BEEF, 3'd0, 3'd0, 1'b0);
        for (int a = 0; a < 8; a++) begin
            step("dec_rd", 8'h00, 32'h0, 3'(a), 3'(a), 1'b0);
            check("dec_rd_const", 64'(bus.rdata1), (a == 0) ? 64'h0 : 64'(a + 32'h100));
        end

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 9));
            wd = $urandom;
            if (r < 2) begin
                we = 8'h00;
            end else if (r < 8) begin
                we = 8'(1 << $urandom_range(0, 7));
            end else begin
                we = 8'($urandom);
                while ($countones(we) < 2) we = 8'($urandom);
            end
            step("rnd", we, wd, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_regbank.md
# onehot_regbank

Eight-entry register bank written through a one-hot write-enable vector. It sits directly downstream of the 3-to-8 write-address decoder: the decoder output `f` drives `we_onehot`, and the decoder enable gates whether any write happens. The block stores the write-back value, serves two registered read ports to the datapath, and flags any illegal multi-hot enable pattern coming from the decoder. Entry 0 is hardwired to zero, following the RISC-V x0 rule.

## Interface
Parameters:
- `WIDTH`, default 32: data width of each entry.
- `CNTW`, default 4: width of the saturating error counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assertion, active-low.
- `we_onehot`  in  8  write enable, one bit per entry, driven by the decoder output.
- `wdata`  in  WIDTH  write data.
- `raddr1`  in  3  read address, port 1.
- `raddr2`  in  3  read address, port 2.
- `clr_err`  in  1  synchronous clear of `err` and `err_cnt`.
- `rdata1`  out  WIDTH  registered read data, port 1.
- `rdata2`  out  WIDTH  registered read data, port 2.
- `err`  out  1  sticky flag: a multi-hot `we_onehot` was seen.
- `err_cnt`  out  CNTW  count of multi-hot cycles, saturating at all-ones.

## Operation
- Write classification, evaluated each cycle:
  - `we_onehot == 0`: idle. No write, no error.
  - Exactly one bit k set: legal write of `wdata` into entry k. For k=0 the write is discarded and is not an error.
  - Two or more bits set: illegal. No entry is written, `err` is set to 1, and `err_cnt` increments by 1, saturating at 2^CNTW-1.
- Entry 0 always reads 0. Entries 1..7 hold their value until a legal write.
- Reads: `rdataN` is loaded with entry[`raddrN`] on each rising edge. The two ports are independent, and both may address the same entry.
- Read-during-write to the same entry in the same cycle: the result depends on `REGBANK_BYPASS_EN` (see Configuration).
- `clr_err`: on the edge, `err` and `err_cnt` are cleared. If the same cycle also carries an illegal vector, the clear is applied first and then the count, so the result is `err`=1 and `err_cnt`=1.
- There is no FSM beyond the storage and error-counter state.

## Timing
- Write: `wdata` is visible in storage after the rising edge on which `we_onehot` is sampled.
- Read latency: 1 cycle from `raddrN` to `rdataN`.
- Error latency: `err` and `err_cnt` update on the same edge that samples the multi-hot vector.
- Reset (`rst_n` low, asynchronous): all entries, `rdata1`, `rdata2`, `err` and `err_cnt` go to 0 immediately.
  - Inputs are ignored while `rst_n` is low.
  - The first capture happens on the first rising edge after `rst_n` deasserts.
  - A write in flight when reset asserts is lost.
- Counter saturation: at all-ones, further illegal vectors hold the count and keep `err`=1.

## Configuration
- `REGBANK_BYPASS_EN` defined: when a legal write targets entry k≠0 and `raddrN == k` in the same cycle, `rdataN` captures `wdata`, i.e. the new value.
- `REGBANK_BYPASS_EN` not defined: `rdataN` captures the old stored value, and the new value is readable from the next cycle.
- Under both settings, reading entry 0 returns 0 and illegal vectors never bypass.

## Test plan
- Reset, then legal writes: write 0xA5A5A5A5 with `we_onehot`=8'b00000100, next cycle `raddr1`=2 → `rdata1`=0xA5A5A5A5 one cycle later; `err`=0.
- x0 rule: `we_onehot`=8'b00000001 with `wdata`=0xFFFFFFFF, then `raddr2`=0 → `rdata2`=0, `err`=0.
- Multi-hot: entry 3 holds 0x11, apply `we_onehot`=8'b00001010 with `wdata`=0x99 → entries 1 and 3 unchanged (entry 3 still 0x11), `err`=1, `err_cnt`=1. Then 16 more illegal cycles → `err_cnt`=15 (saturated). Then `clr_err` → 0/0.
- Same-cycle read/write: entry 5 holds 0x22, write 0x33 to entry 5 while `raddr1`=5 → `rdata1`=0x33 with `REGBANK_BYPASS_EN` defined, 0x22 without it; the following cycle reads 0x33 under both settings.
- Async reset mid-operation: entries loaded with nonzero values and `err`=1, pulse `rst_n` low between clock edges → all outputs read 0 before the next edge, and reads of entries 1..7 return 0.
- Decoder chain: instantiate the 3-to-8 decoder feeding `we_onehot` and sweep a=0..7 with e=1, writing value a+0x100 → entries 1..7 read back a+0x100, entry 0 reads 0; e=0 writes nothing.
